// File: rtl/c3aibadapt_txeq_pkg.sv
// Shared encodings for the TX-equalisation coefficient path: controller states,
// direction-feedback codes and the bit offsets of each field in the feedback word.
package c3aibadapt_txeq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_APPLY = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } txeq_state_e;

   localparam logic [1:0] FB_HOLD    = 2'b00;
   localparam logic [1:0] FB_INC     = 2'b01;
   localparam logic [1:0] FB_DEC     = 2'b10;
   localparam logic [1:0] FB_ILLEGAL = 2'b11;

   localparam int unsigned FB_POST = 0;
   localparam int unsigned FB_MAIN = 2;
   localparam int unsigned FB_PRE  = 4;

endpackage

// File: rtl/c3aibadapt_txeq_coef_chk.sv
// Combinational FS/LF legality check for a (pre, post) coefficient pair; also
// produces the derived main cursor. Shared with the TX-side preset checker.
module c3aibadapt_txeq_coef_chk #(
   parameter int unsigned CW = 6
)(
   input  logic [CW-1:0] i_pre,
   input  logic [CW-1:0] i_post,
   input  logic [CW-1:0] i_fs,
   input  logic [CW-1:0] i_lf,
   output logic [CW-1:0] o_main,
   output logic          o_legal
);

   logic signed [CW+1:0] w_pre;
   logic signed [CW+1:0] w_post;
   logic signed [CW+1:0] w_fs;
   logic signed [CW+1:0] w_lf;
   logic signed [CW+1:0] w_sum;
   logic signed [CW+1:0] w_margin;

   assign w_pre    = {2'b00, i_pre};
   assign w_post   = {2'b00, i_post};
   assign w_fs     = {2'b00, i_fs};
   assign w_lf     = {2'b00, i_lf};
   assign w_sum    = w_pre + w_post;
   // margin may wrap only when sum > FS, which the second term already rejects
   assign w_margin = (w_fs - w_sum) - w_sum;

   assign o_main  = i_fs - i_pre - i_post;
   assign o_legal = (w_pre <= (w_fs >>> 2)) && (w_sum <= w_fs) && (w_margin >= w_lf);

endmodule

// File: rtl/c3aibadapt_txeq_coef_acc.sv
// Far-end TX coefficient accumulator: applies direction feedback to C-1/C+1,
// checks each candidate against FS/LF and commits or rejects it.
module c3aibadapt_txeq_coef_acc
   import c3aibadapt_txeq_pkg::*;
#(
   parameter int unsigned CW = 6,
   parameter int unsigned IW = 4
)(
   input  logic          rx_clock_txeq_clk,
   input  logic          rx_reset_txeq_clk_rst_n,
   input  logic          txeq_phystatus,
   input  logic [5:0]    txeq_dirfeedback,
   input  logic          eq_start,
   input  logic [CW-1:0] r_txeq_fs,
   input  logic [CW-1:0] r_txeq_lf,
   input  logic [CW-1:0] r_txeq_init_pre,
   input  logic [CW-1:0] r_txeq_init_post,
   input  logic [IW-1:0] r_txeq_max_iter,
   output logic [CW-1:0] tx_coef_pre,
   output logic [CW-1:0] tx_coef_post,
   output logic [CW-1:0] tx_coef_main,
   output logic          coef_update,
   output logic          coef_reject,
   output logic          eq_done,
   output logic          eq_converged,
   output logic [7:0]    coef_acc_testbus
);

   txeq_state_e   r_st;
   logic          r_start_d;
   logic [1:0]    r_fb_pre;
   logic [1:0]    r_fb_post;
   logic [CW-1:0] r_cand_pre;
   logic [CW-1:0] r_cand_post;
   logic [CW-1:0] r_pre;
   logic [CW-1:0] r_post;
   logic [CW-1:0] r_main;
   logic [IW-1:0] r_iter;
   logic          r_update;
   logic          r_reject;
   logic          r_done;
   logic          r_conv;
   logic          r_fb_illegal;

   logic [CW-1:0] w_init_main;
   logic [CW-1:0] w_chk_main;
   logic          w_chk_legal;
   logic          w_last_iter;
   logic [1:0]    w_unused_main_fb;

   function automatic logic [CW-1:0] f_step(input logic [CW-1:0] v, input logic [1:0] code);
      f_step = v;
      if (code == FB_INC && v != '1)
         f_step = v + CW'(1);
      else if (code == FB_DEC && v != '0)
         f_step = v - CW'(1);
   endfunction

   assign w_unused_main_fb = txeq_dirfeedback[FB_MAIN +: 2];
   assign w_init_main      = r_txeq_fs - r_txeq_init_pre - r_txeq_init_post;
   assign w_last_iter      = (r_txeq_max_iter != '0) && ((r_iter + IW'(1)) == r_txeq_max_iter);

   c3aibadapt_txeq_coef_chk #(.CW(CW)) u_coef_chk (
      .i_pre   (r_cand_pre),
      .i_post  (r_cand_post),
      .i_fs    (r_txeq_fs),
      .i_lf    (r_txeq_lf),
      .o_main  (w_chk_main),
      .o_legal (w_chk_legal)
   );

   always_ff @(posedge rx_clock_txeq_clk or negedge rx_reset_txeq_clk_rst_n) begin
      if (!rx_reset_txeq_clk_rst_n) begin
         r_st         <= ST_IDLE;
         r_start_d    <= 1'b0;
         r_fb_pre     <= FB_HOLD;
         r_fb_post    <= FB_HOLD;
         r_cand_pre   <= '0;
         r_cand_post  <= '0;
         r_pre        <= '0;
         r_post       <= '0;
         r_main       <= '0;
         r_iter       <= '0;
         r_update     <= 1'b0;
         r_reject     <= 1'b0;
         r_done       <= 1'b0;
         r_conv       <= 1'b0;
         r_fb_illegal <= 1'b0;
      end else begin
         r_start_d <= eq_start;
         r_update  <= 1'b0;
         r_reject  <= 1'b0;
         // dropping eq_start outranks every state action, including a pending CHECK
         if (r_st != ST_IDLE && !eq_start) begin
            r_st <= ST_IDLE;
         end else begin
            case (r_st)
               ST_IDLE: begin
                  if (eq_start && !r_start_d) begin
                     r_pre  <= r_txeq_init_pre;
                     r_post <= r_txeq_init_post;
                     r_main <= w_init_main;
                     r_iter <= '0;
                     r_done <= 1'b0;
                     r_conv <= 1'b0;
                     r_st   <= ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  if (txeq_phystatus) begin
                     r_fb_pre  <= txeq_dirfeedback[FB_PRE +: 2];
                     r_fb_post <= txeq_dirfeedback[FB_POST +: 2];
                     r_st      <= ST_APPLY;
                  end
               end
               ST_APPLY: begin
                  r_cand_pre  <= f_step(r_pre, r_fb_pre);
                  r_cand_post <= f_step(r_post, r_fb_post);
                  if (r_fb_pre == FB_ILLEGAL || r_fb_post == FB_ILLEGAL)
                     r_fb_illegal <= 1'b1;
                  if (r_fb_pre == FB_HOLD && r_fb_post == FB_HOLD) begin
                     r_conv <= 1'b1;
                     r_done <= 1'b1;
                     r_st   <= ST_DONE;
                  end else begin
                     r_st <= ST_CHECK;
                  end
               end
               ST_CHECK: begin
                  r_update <= 1'b1;
                  r_reject <= !w_chk_legal;
                  if (w_chk_legal) begin
                     r_pre  <= r_cand_pre;
                     r_post <= r_cand_post;
                     r_main <= w_chk_main;
                  end
                  if (r_iter != '1)
                     r_iter <= r_iter + IW'(1);
                  if (w_last_iter) begin
                     r_done <= 1'b1;
                     r_st   <= ST_DONE;
                  end else begin
                     r_st <= ST_WAIT;
                  end
               end
               ST_DONE: ;
               default: r_st <= ST_IDLE;
            endcase
         end
      end
   end

   assign tx_coef_pre      = r_pre;
   assign tx_coef_post     = r_post;
   assign tx_coef_main     = r_main;
   assign coef_update      = r_update;
   assign coef_reject      = r_reject;
   assign eq_done          = r_done;
   assign eq_converged     = r_conv;
   assign coef_acc_testbus = {r_iter, r_fb_illegal, r_st};

endmodule

// File: tb/tb_c3aibadapt_txeq_coef_acc.sv
// Bench for c3aibadapt_txeq_coef_acc: directed runs against an integer reference
// model, with hand-computed spot checks of coefficients and status.
module tb_c3aibadapt_txeq_coef_acc;

   localparam int CW = 6;
   localparam int IW = 4;
   localparam int CMAX = (1 << CW) - 1;
   localparam int IMAX = (1 << IW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          phys = 1'b0;
   logic [5:0]    fb = '0;
   logic          start = 1'b0;
   logic [CW-1:0] fs = 6'd40;
   logic [CW-1:0] lf = 6'd10;
   logic [CW-1:0] ipre = 6'd4;
   logic [CW-1:0] ipost = 6'd8;
   logic [IW-1:0] maxit = '0;
   logic [CW-1:0] pre, post, main_c;
   logic          upd, rej, done, conv;
   logic [7:0]    tbus;
   logic          cmp_en = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   c3aibadapt_txeq_coef_acc #(.CW(CW), .IW(IW)) dut (
      .rx_clock_txeq_clk       (clk),
      .rx_reset_txeq_clk_rst_n (rst_n),
      .txeq_phystatus          (phys),
      .txeq_dirfeedback        (fb),
      .eq_start                (start),
      .r_txeq_fs               (fs),
      .r_txeq_lf               (lf),
      .r_txeq_init_pre         (ipre),
      .r_txeq_init_post        (ipost),
      .r_txeq_max_iter         (maxit),
      .tx_coef_pre             (pre),
      .tx_coef_post            (post),
      .tx_coef_main            (main_c),
      .coef_update             (upd),
      .coef_reject             (rej),
      .eq_done                 (done),
      .eq_converged            (conv),
      .coef_acc_testbus        (tbus)
   );

   // Reference model: integer coefficients, phase = position in the
   // idle / awaiting-feedback / applying / evaluating / finished sequence.
   int m_pre, m_post, m_main, m_iter, m_phase, m_cp, m_cq, m_fpre, m_fpost;
   bit m_upd, m_rej, m_done, m_conv, m_ill, m_sd;

   function automatic int step(input int v, input int code);
      if (code == 1) return (v < CMAX) ? v + 1 : CMAX;
      if (code == 2) return (v > 0) ? v - 1 : 0;
      return v;
   endfunction

   function automatic bit legal(input int p, input int q, input int f, input int l);
      return (p <= f / 4) && (p + q <= f) && ((f - p - q) - p - q >= l);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pre = 0; m_post = 0; m_main = 0; m_iter = 0; m_phase = 0;
         m_cp = 0; m_cq = 0; m_fpre = 0; m_fpost = 0;
         m_upd = 0; m_rej = 0; m_done = 0; m_conv = 0; m_ill = 0; m_sd = 0;
      end else begin
         bit prev_start;
         prev_start = m_sd;
         m_sd  = start;
         m_upd = 0;
         m_rej = 0;
         if (m_phase != 0 && !start) begin
            m_phase = 0;
         end else if (m_phase == 0) begin
            if (start && !prev_start) begin
               m_pre = int'(ipre); m_post = int'(ipost);
               m_main = (int'(fs) - m_pre - m_post) & CMAX;
               m_iter = 0; m_done = 0; m_conv = 0; m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (phys) begin
               m_fpre = int'(fb[5:4]); m_fpost = int'(fb[1:0]); m_phase = 2;
            end
         end else if (m_phase == 2) begin
            m_cp = step(m_pre, m_fpre);
            m_cq = step(m_post, m_fpost);
            if (m_fpre == 3 || m_fpost == 3) m_ill = 1;
            if (m_fpre == 0 && m_fpost == 0) begin
               m_conv = 1; m_done = 1; m_phase = 4;
            end else begin
               m_phase = 3;
            end
         end else if (m_phase == 3) begin
            int old_iter;
            m_upd = 1;
            if (legal(m_cp, m_cq, int'(fs), int'(lf))) begin
               m_pre = m_cp; m_post = m_cq; m_main = int'(fs) - m_cp - m_cq;
            end else begin
               m_rej = 1;
            end
            old_iter = m_iter;
            m_iter = (m_iter < IMAX) ? m_iter + 1 : IMAX;
            if (maxit != 0 && old_iter + 1 == int'(maxit)) begin
               m_done = 1; m_phase = 4;
            end else begin
               m_phase = 1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_pre", 32'(pre), 32'(m_pre));
         chk("m_post", 32'(post), 32'(m_post));
         chk("m_main", 32'(main_c), 32'(m_main));
         chk("m_update", 32'(upd), 32'(m_upd));
         chk("m_reject", 32'(rej), 32'(m_rej));
         chk("m_done", 32'(done), 32'(m_done));
         chk("m_conv", 32'(conv), 32'(m_conv));
         chk("m_testbus", 32'(tbus), 32'((m_iter << 4) | (int'(m_ill) << 3) | m_phase));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [5:0] v);
      phys = 1'b1;
      fb   = v;
      cyc();
      phys = 1'b0;
      fb   = '0;
      cyc();
      cyc();
   endtask

   initial begin
      repeat (2) cyc();
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      cyc();
      chk("rst_pre", 32'(pre), 0);
      chk("rst_testbus", 32'(tbus), 0);
      chk("rst_done", 32'(done), 0);

      // basic start and first post increment
      start = 1'b1;
      cyc();
      chk("t1_pre", 32'(pre), 4);
      chk("t1_post", 32'(post), 8);
      chk("t1_main", 32'(main_c), 28);
      chk("t1_st", 32'(tbus[2:0]), 1);
      send(6'b000001);
      chk("t1_post9", 32'(post), 9);
      chk("t1_main27", 32'(main_c), 27);
      chk("t1_upd", 32'(upd), 1);
      chk("t1_rej", 32'(rej), 0);

      // walk post up to the LF limit
      send(6'b000001);
      send(6'b000001);
      chk("t2_post11", 32'(post), 11);
      chk("t2_main25", 32'(main_c), 25);
      send(6'b000001);
      chk("t2_rej", 32'(rej), 1);
      chk("t2_upd", 32'(upd), 1);
      chk("t2_post_hold", 32'(post), 11);

      // pre at FS/4 boundary
      start = 1'b0;
      cyc();
      chk("t3_abort_st", 32'(tbus[2:0]), 0);
      ipre = 6'd10; ipost = 6'd4;
      start = 1'b1;
      cyc();
      chk("t3_main", 32'(main_c), 26);
      send(6'b010000);
      chk("t3_rej", 32'(rej), 1);
      chk("t3_pre_hold", 32'(pre), 10);
      send(6'b100000);
      chk("t3_pre9", 32'(pre), 9);
      chk("t3_main27", 32'(main_c), 27);
      chk("t3_rej0", 32'(rej), 0);

      // all-hold feedback converges (C0 field ignored)
      send(6'b001100);
      chk("t4_upd", 32'(upd), 0);
      chk("t4_done", 32'(done), 1);
      chk("t4_conv", 32'(conv), 1);
      chk("t4_st", 32'(tbus[2:0]), 4);
      start = 1'b0;
      cyc();
      chk("t4_idle", 32'(tbus[2:0]), 0);
      chk("t4_done_held", 32'(done), 1);

      // iteration limit
      ipre = 6'd4; ipost = 6'd8; maxit = 4'd3;
      start = 1'b1;
      cyc();
      chk("t5_done_clr", 32'(done), 0);
      repeat (3) send(6'b000001);
      chk("t5_done", 32'(done), 1);
      chk("t5_conv", 32'(conv), 0);
      chk("t5_iter", 32'(tbus[7:4]), 3);
      chk("t5_post", 32'(post), 11);
      send(6'b000001);
      chk("t5_ignored", 32'(post), 11);

      // illegal field code and iteration saturation
      start = 1'b0; maxit = '0;
      cyc();
      start = 1'b1;
      cyc();
      send(6'b000011);
      chk("t6_upd", 32'(upd), 1);
      chk("t6_post", 32'(post), 8);
      chk("t6_ill", 32'(tbus[3]), 1);
      repeat (16) send(6'b000011);
      chk("t6_iter_sat", 32'(tbus[7:4]), 15);

      // coefficient saturation at zero
      start = 1'b0;
      cyc();
      fs = 6'd63; lf = 6'd0; ipre = 6'd0; ipost = 6'd0;
      start = 1'b1;
      cyc();
      chk("t7_main63", 32'(main_c), 63);
      send(6'b100010);
      chk("t7_pre0", 32'(pre), 0);
      chk("t7_post0", 32'(post), 0);
      chk("t7_upd", 32'(upd), 1);

      // abort coinciding with CHECK
      phys = 1'b1; fb = 6'b000001;
      cyc();
      phys = 1'b0; fb = '0;
      cyc();
      start = 1'b0;
      cyc();
      chk("t8_no_upd", 32'(upd), 0);
      chk("t8_idle", 32'(tbus[2:0]), 0);
      chk("t8_post_hold", 32'(post), 0);

      // asynchronous reset mid-run
      start = 1'b1;
      cyc();
      phys = 1'b1; fb = 6'b000001;
      cyc();
      phys = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t9_main", 32'(main_c), 0);
      chk("t9_testbus", 32'(tbus), 0);
      chk("t9_done", 32'(done), 0);
      start = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
